// File: rtl/vx_stream_rr_arbiter.sv
// Round-robin many-to-one valid/ready stream arbiter with optional packet lock
// and an optional 2-entry skid buffer on the output side.
module vx_stream_rr_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = 32,
    parameter bit LOCK_PKT     = 1'b1,
    parameter bit OUT_REG      = 1'b1,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            valid_in,
    input  logic [NUM_REQS-1:0][DATAW-1:0] data_in,
    input  logic [NUM_REQS-1:0]            last_in,
    output logic [NUM_REQS-1:0]            ready_in,
    output logic                           valid_out,
    output logic [DATAW-1:0]               data_out,
    output logic                           last_out,
    output logic [LOG_NUM_REQS-1:0]        sel_out,
    input  logic                           ready_out
);
    typedef logic [LOG_NUM_REQS-1:0] idx_t;
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t state;
    idx_t   rr_ptr;
    idx_t   grant_idx;
    logic   hold;

    idx_t   cand_idx;
    idx_t   next_ptr;
    logic   cand_valid;
    logic   sink_ready;
    logic   fire;

    // A latched grant (packet lock or a presented-but-unaccepted beat) overrides the scan.
    always_comb begin : arb_scan
        idx_t c;
        c          = '0;
        cand_idx   = '0;
        cand_valid = 1'b0;
        if (state == LOCKED || hold) begin
            cand_idx   = grant_idx;
            cand_valid = valid_in[grant_idx];
        end else begin
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                c = idx_t'((32'(rr_ptr) + i) % NUM_REQS);
                if (!cand_valid && valid_in[c]) begin
                    cand_valid = 1'b1;
                    cand_idx   = c;
                end
            end
        end
    end

    always_comb begin
        next_ptr = (cand_idx == idx_t'(NUM_REQS - 1)) ? '0 : cand_idx + 1'b1;
        fire     = cand_valid & sink_ready;
        for (int unsigned g = 0; g < NUM_REQS; g++) begin
            ready_in[g] = reset & sink_ready & cand_valid & (cand_idx == idx_t'(g));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            hold      <= 1'b0;
        end else if (fire) begin
            hold <= 1'b0;
            if (LOCK_PKT && !last_in[cand_idx]) begin
                state     <= LOCKED;
                grant_idx <= cand_idx;
            end else begin
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end
        end else if (cand_valid && state == IDLE && !hold) begin
            hold      <= 1'b1;
            grant_idx <= cand_idx;
        end
    end

    if (OUT_REG) begin : g_skid
        typedef struct packed {
            logic [DATAW-1:0] data;
            logic             last;
            idx_t             sel;
        } entry_t;

        entry_t     mem [2];
        logic       wr_ptr;
        logic       rd_ptr;
        logic [1:0] count;
        logic       pop;

        assign sink_ready = (count != 2'd2);
        assign pop        = (count != 2'd0) & ready_out;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem[0] <= '0;
                mem[1] <= '0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= '0;
            end else begin
                if (fire) begin
                    mem[wr_ptr] <= '{data: data_in[cand_idx], last: last_in[cand_idx], sel: cand_idx};
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, fire} - {1'b0, pop};
            end
        end

        assign valid_out = (count != 2'd0);
        assign data_out  = mem[rd_ptr].data;
        assign last_out  = mem[rd_ptr].last;
        assign sel_out   = mem[rd_ptr].sel;
    end else begin : g_comb
        assign sink_ready = ready_out;
        assign valid_out  = reset & cand_valid;
        assign data_out   = (reset && cand_valid) ? data_in[cand_idx] : '0;
        assign last_out   = reset & cand_valid & last_in[cand_idx];
        assign sel_out    = reset ? cand_idx : '0;
    end

endmodule

// File: tb/tb_vx_stream_rr_arbiter.sv
// Directed bench for vx_stream_rr_arbiter across three parameter sets sharing one stimulus bus.
module tb_vx_stream_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int LW = 2;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]        valid_in;
    logic [N-1:0]        last_in;
    logic [N-1:0][W-1:0] data_in;
    logic                ready_out;

    logic [N-1:0] a_ready_in, b_ready_in, c_ready_in;
    logic         a_valid_out, b_valid_out, c_valid_out;
    logic [W-1:0] a_data_out, b_data_out, c_data_out;
    logic         a_last_out, b_last_out, c_last_out;
    logic [LW-1:0] a_sel_out, b_sel_out, c_sel_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // a: per-beat arbitration, combinational output
    vx_stream_rr_arbiter #(.NUM_REQS(N), .DATAW(W), .LOCK_PKT(1'b0), .OUT_REG(1'b0)) u_a (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_in(a_ready_in), .valid_out(a_valid_out), .data_out(a_data_out),
        .last_out(a_last_out), .sel_out(a_sel_out), .ready_out(ready_out));

    // b: packet lock, combinational output
    vx_stream_rr_arbiter #(.NUM_REQS(N), .DATAW(W), .LOCK_PKT(1'b1), .OUT_REG(1'b0)) u_b (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_in(b_ready_in), .valid_out(b_valid_out), .data_out(b_data_out),
        .last_out(b_last_out), .sel_out(b_sel_out), .ready_out(ready_out));

    // c: packet lock, skid-buffered output
    vx_stream_rr_arbiter #(.NUM_REQS(N), .DATAW(W), .LOCK_PKT(1'b1), .OUT_REG(1'b1)) u_c (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
        .ready_in(c_ready_in), .valid_out(c_valid_out), .data_out(c_data_out),
        .last_out(c_last_out), .sel_out(c_sel_out), .ready_out(ready_out));

    task automatic idle_inputs();
        valid_in  = '0;
        last_in   = '0;
        data_in   = '0;
        ready_out = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        valid_in  = '1;
        last_in   = '1;
        ready_out = 1'b1;
        for (int i = 0; i < N; i++) data_in[i] = 32'h5A5A_0000 + 32'(i);
        reset = 1'b0;
        #1;
        checks++; if (a_valid_out !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %0b want 0", a_valid_out); end
        checks++; if (a_ready_in !== 4'b0000) begin errors++; $display("FAIL reset_a_ready: got %b want 0000", a_ready_in); end
        checks++; if (a_data_out !== 32'h0) begin errors++; $display("FAIL reset_a_data: got %h want 0", a_data_out); end
        checks++; if (b_ready_in !== 4'b0000) begin errors++; $display("FAIL reset_b_ready: got %b want 0000", b_ready_in); end
        checks++; if (b_last_out !== 1'b0) begin errors++; $display("FAIL reset_b_last: got %0b want 0", b_last_out); end
        checks++; if (c_valid_out !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %0b want 0", c_valid_out); end
        checks++; if (c_ready_in !== 4'b0000) begin errors++; $display("FAIL reset_c_ready: got %b want 0000", c_ready_in); end
        checks++; if (c_data_out !== 32'h0) begin errors++; $display("FAIL reset_c_data: got %h want 0", c_data_out); end
        checks++; if (c_sel_out !== 2'd0) begin errors++; $display("FAIL reset_c_sel: got %0d want 0", c_sel_out); end
        checks++; if (c_last_out !== 1'b0) begin errors++; $display("FAIL reset_c_last: got %0b want 0", c_last_out); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    // All requesters valid with single-beat packets: strict rotation 0,1,2,3,0...
    task automatic test_rr_rotation();
        logic [N-1:0] exp_rdy;
        do_reset();
        valid_in  = '1;
        last_in   = '1;
        ready_out = 1'b1;
        for (int i = 0; i < N; i++) data_in[i] = 32'hA0 + 32'(i);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % N);
            checks++; if (a_valid_out !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %0b want 1", k, a_valid_out); end
            checks++; if (a_sel_out !== 2'(k % N)) begin errors++; $display("FAIL rr_sel[%0d]: got %0d want %0d", k, a_sel_out, k % N); end
            checks++; if (a_data_out !== 32'hA0 + 32'(k % N)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, a_data_out, 32'hA0 + 32'(k % N)); end
            checks++; if (a_ready_in !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, a_ready_in, exp_rdy); end
            checks++; if (a_last_out !== 1'b1) begin errors++; $display("FAIL rr_last[%0d]: got %0b want 1", k, a_last_out); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_packet_lock();
        do_reset();
        ready_out  = 1'b1;
        data_in[0] = 32'h100;
        data_in[1] = 32'h110;
        data_in[3] = 32'h130;
        // single beat from req1 moves rr_ptr to 2
        valid_in = 4'b0010; last_in = 4'b0010;
        #1;
        checks++; if (b_sel_out !== 2'd1) begin errors++; $display("FAIL lock_pre_sel: got %0d want 1", b_sel_out); end
        checks++; if (b_ready_in !== 4'b0010) begin errors++; $display("FAIL lock_pre_ready: got %b want 0010", b_ready_in); end
        @(negedge clk);
        valid_in = 4'b0111; last_in = 4'b0011; data_in[2] = 32'h121;
        #1;
        checks++; if (b_sel_out !== 2'd2) begin errors++; $display("FAIL lock_b1_sel: got %0d want 2", b_sel_out); end
        checks++; if (b_ready_in !== 4'b0100) begin errors++; $display("FAIL lock_b1_ready: got %b want 0100", b_ready_in); end
        checks++; if (b_last_out !== 1'b0) begin errors++; $display("FAIL lock_b1_last: got %0b want 0", b_last_out); end
        checks++; if (b_data_out !== 32'h121) begin errors++; $display("FAIL lock_b1_data: got %h want 121", b_data_out); end
        @(negedge clk);
        valid_in = 4'b1111; last_in = 4'b1011; data_in[2] = 32'h122;
        #1;
        checks++; if (b_sel_out !== 2'd2) begin errors++; $display("FAIL lock_b2_sel: got %0d want 2", b_sel_out); end
        checks++; if (b_ready_in !== 4'b0100) begin errors++; $display("FAIL lock_b2_ready: got %b want 0100", b_ready_in); end
        checks++; if (b_data_out !== 32'h122) begin errors++; $display("FAIL lock_b2_data: got %h want 122", b_data_out); end
        @(negedge clk);
        last_in = 4'b1111; data_in[2] = 32'h123;
        #1;
        checks++; if (b_sel_out !== 2'd2) begin errors++; $display("FAIL lock_b3_sel: got %0d want 2", b_sel_out); end
        checks++; if (b_last_out !== 1'b1) begin errors++; $display("FAIL lock_b3_last: got %0b want 1", b_last_out); end
        checks++; if (b_ready_in !== 4'b0100) begin errors++; $display("FAIL lock_b3_ready: got %b want 0100", b_ready_in); end
        @(negedge clk);
        valid_in = 4'b1011;
        #1;
        checks++; if (b_sel_out !== 2'd3) begin errors++; $display("FAIL lock_next_sel: got %0d want 3", b_sel_out); end
        checks++; if (b_ready_in !== 4'b1000) begin errors++; $display("FAIL lock_next_ready: got %b want 1000", b_ready_in); end
        checks++; if (b_data_out !== 32'h130) begin errors++; $display("FAIL lock_next_data: got %h want 130", b_data_out); end
        @(negedge clk);
        valid_in = 4'b0011;
        #1;
        checks++; if (b_sel_out !== 2'd0) begin errors++; $display("FAIL lock_wrap_sel: got %0d want 0", b_sel_out); end
        checks++; if (b_ready_in !== 4'b0001) begin errors++; $display("FAIL lock_wrap_ready: got %b want 0001", b_ready_in); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure_hold();
        do_reset();
        ready_out  = 1'b0;
        data_in[0] = 32'h200;
        data_in[1] = 32'h210;
        valid_in = 4'b0010; last_in = 4'b0010;
        #1;
        checks++; if (b_sel_out !== 2'd1) begin errors++; $display("FAIL bp_first_sel: got %0d want 1", b_sel_out); end
        checks++; if (b_valid_out !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %0b want 1", b_valid_out); end
        @(negedge clk);
        valid_in = 4'b0011; last_in = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (b_sel_out !== 2'd1) begin errors++; $display("FAIL bp_hold_sel[%0d]: got %0d want 1", k, b_sel_out); end
            checks++; if (b_data_out !== 32'h210) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want 210", k, b_data_out); end
            checks++; if (b_ready_in !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", k, b_ready_in); end
            @(negedge clk);
        end
        ready_out = 1'b1;
        #1;
        checks++; if (b_ready_in !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b want 0010", b_ready_in); end
        checks++; if (b_data_out !== 32'h210) begin errors++; $display("FAIL bp_release_data: got %h want 210", b_data_out); end
        @(negedge clk);
        valid_in = 4'b0001;
        #1;
        checks++; if (b_sel_out !== 2'd0) begin errors++; $display("FAIL bp_after_sel: got %0d want 0", b_sel_out); end
        checks++; if (b_data_out !== 32'h200) begin errors++; $display("FAIL bp_after_data: got %h want 200", b_data_out); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_lock_gap();
        do_reset();
        ready_out  = 1'b1;
        data_in[0] = 32'h300;
        data_in[2] = 32'h321;
        valid_in = 4'b0100; last_in = 4'b0000;
        #1;
        checks++; if (b_ready_in !== 4'b0100) begin errors++; $display("FAIL gap_start_ready: got %b want 0100", b_ready_in); end
        @(negedge clk);
        valid_in = 4'b0001; last_in = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (b_ready_in !== 4'b0000) begin errors++; $display("FAIL gap_ready[%0d]: got %b want 0000", k, b_ready_in); end
            checks++; if (b_valid_out !== 1'b0) begin errors++; $display("FAIL gap_valid[%0d]: got %0b want 0", k, b_valid_out); end
            @(negedge clk);
        end
        valid_in = 4'b0101; last_in = 4'b0101; data_in[2] = 32'h322;
        #1;
        checks++; if (b_sel_out !== 2'd2) begin errors++; $display("FAIL gap_resume_sel: got %0d want 2", b_sel_out); end
        checks++; if (b_ready_in !== 4'b0100) begin errors++; $display("FAIL gap_resume_ready: got %b want 0100", b_ready_in); end
        checks++; if (b_data_out !== 32'h322) begin errors++; $display("FAIL gap_resume_data: got %h want 322", b_data_out); end
        @(negedge clk);
        valid_in = 4'b0001;
        #1;
        checks++; if (b_ready_in !== 4'b0001) begin errors++; $display("FAIL gap_after_ready: got %b want 0001", b_ready_in); end
        checks++; if (b_data_out !== 32'h300) begin errors++; $display("FAIL gap_after_data: got %h want 300", b_data_out); end
        @(negedge clk);
        idle_inputs();
    endtask

    // Four requesters, eight beats each (2-beat packets), ready_out toggling 1,0,1,0...
    task automatic test_skid_stream();
        int sent [N];
        int rcvd [N];
        int occ;
        int cyc;
        int total;
        int s;
        do_reset();
        for (int i = 0; i < N; i++) begin sent[i] = 0; rcvd[i] = 0; end
        occ = 0; cyc = 0; total = 0;
        while (total < N * 8 && cyc < 400) begin
            for (int i = 0; i < N; i++) begin
                valid_in[i] = (sent[i] < 8);
                data_in[i]  = {8'(i), 24'(sent[i])};
                last_in[i]  = 1'((sent[i] % 2) == 1);
            end
            ready_out = ((cyc % 2) == 0);
            #1;
            if (occ == 2) begin
                checks++; if (c_ready_in !== 4'b0000) begin errors++; $display("FAIL skid_full_ready[%0d]: got %b want 0000", cyc, c_ready_in); end
            end
            checks++; if (c_valid_out !== (occ != 0)) begin errors++; $display("FAIL skid_valid[%0d]: got %0b want %0b", cyc, c_valid_out, occ != 0); end
            checks++; if (!$onehot0(c_ready_in) || (c_ready_in & ~valid_in) != '0) begin
                errors++; $display("FAIL skid_ready_legal[%0d]: got %b want onehot0 within %b", cyc, c_ready_in, valid_in);
            end
            if (c_valid_out && ready_out) begin
                s = int'(c_sel_out);
                checks++; if (c_data_out !== {8'(s), 24'(rcvd[s])}) begin errors++; $display("FAIL skid_data[%0d]: got %h want %h", cyc, c_data_out, {8'(s), 24'(rcvd[s])}); end
                checks++; if (c_last_out !== 1'((rcvd[s] % 2) == 1)) begin errors++; $display("FAIL skid_last[%0d]: got %0b want %0b", cyc, c_last_out, (rcvd[s] % 2) == 1); end
                rcvd[s]++;
                total++;
                occ--;
            end
            for (int i = 0; i < N; i++) begin
                if (valid_in[i] && c_ready_in[i]) begin
                    sent[i]++;
                    occ++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc >= 400) begin errors++; $display("FAIL skid_timeout: got %0d cycles want under 400", cyc); end
        for (int i = 0; i < N; i++) begin
            checks++; if (rcvd[i] !== 8) begin errors++; $display("FAIL skid_count[%0d]: got %0d want 8", i, rcvd[i]); end
        end
        checks++; if (occ !== 0) begin errors++; $display("FAIL skid_drain: got occupancy %0d want 0", occ); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        ready_out  = 1'b0;
        data_in[0] = 32'h400;
        valid_in = 4'b0001; last_in = 4'b0001;
        #1;
        checks++; if (c_ready_in !== 4'b0001) begin errors++; $display("FAIL rmp_b0_ready: got %b want 0001", c_ready_in); end
        @(negedge clk);
        valid_in = 4'b0010; last_in = 4'b0000; data_in[1] = 32'h411;
        #1;
        checks++; if (c_ready_in !== 4'b0010) begin errors++; $display("FAIL rmp_b1_ready: got %b want 0010", c_ready_in); end
        @(negedge clk);
        data_in[1] = 32'h412;
        #1;
        checks++; if (c_valid_out !== 1'b1) begin errors++; $display("FAIL rmp_full_valid: got %0b want 1", c_valid_out); end
        checks++; if (c_ready_in !== 4'b0000) begin errors++; $display("FAIL rmp_full_ready: got %b want 0000", c_ready_in); end
        reset = 1'b0;
        #1;
        checks++; if (c_valid_out !== 1'b0) begin errors++; $display("FAIL rmp_async_valid: got %0b want 0", c_valid_out); end
        checks++; if (c_sel_out !== 2'd0) begin errors++; $display("FAIL rmp_async_sel: got %0d want 0", c_sel_out); end
        checks++; if (c_data_out !== 32'h0) begin errors++; $display("FAIL rmp_async_data: got %h want 0", c_data_out); end
        checks++; if (c_ready_in !== 4'b0000) begin errors++; $display("FAIL rmp_async_ready: got %b want 0000", c_ready_in); end
        @(negedge clk);
        reset = 1'b1;
        valid_in = 4'b0011; last_in = 4'b0011; ready_out = 1'b1;
        data_in[0] = 32'h4F0; data_in[1] = 32'h4F1;
        #1;
        checks++; if (c_ready_in !== 4'b0001) begin errors++; $display("FAIL rmp_post_ready: got %b want 0001", c_ready_in); end
        checks++; if (c_valid_out !== 1'b0) begin errors++; $display("FAIL rmp_post_empty: got %0b want 0", c_valid_out); end
        @(negedge clk);
        #1;
        checks++; if (c_valid_out !== 1'b1) begin errors++; $display("FAIL rmp_out_valid: got %0b want 1", c_valid_out); end
        checks++; if (c_sel_out !== 2'd0) begin errors++; $display("FAIL rmp_out_sel: got %0d want 0", c_sel_out); end
        checks++; if (c_data_out !== 32'h4F0) begin errors++; $display("FAIL rmp_out_data: got %h want 4f0", c_data_out); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_rr_rotation();
        test_packet_lock();
        test_backpressure_hold();
        test_lock_gap();
        test_skid_stream();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
